// File: rtl/alu_disp_pkg.sv
// Shared types and constants for the ALU result display: FSM states,
// digit count and active-low gfedcba segment patterns.
package alu_disp_pkg;

    localparam int unsigned NUM_DIGITS = 3;
    localparam int unsigned DIGIT_W    = 4;
    localparam int unsigned SEG_W      = 7;
    localparam int unsigned Y_W        = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CONV   = 2'd1,
        COMMIT = 2'd2
    } state_t;

    localparam logic [SEG_W-1:0] SEG_BLANK = 7'b1111111;
    localparam logic [SEG_W-1:0] SEG_E     = 7'b0000110;

    // Index by nibble; entries 10-15 show "E" so the decoder needs no range check.
    localparam logic [15:0][SEG_W-1:0] SEG_TABLE = {
        SEG_E, SEG_E, SEG_E, SEG_E, SEG_E, SEG_E,
        7'b0010000,   // 9
        7'b0000000,   // 8
        7'b1111000,   // 7
        7'b0000010,   // 6
        7'b0010010,   // 5
        7'b0011001,   // 4
        7'b0110000,   // 3
        7'b0100100,   // 2
        7'b1111001,   // 1
        7'b1000000    // 0
    };

endpackage

// File: rtl/alu_result_display_seg7_decode.sv
// Combinational nibble to active-low 7-segment decoder with blank override.
module seg7_decode
    import alu_disp_pkg::*;
(
    input  logic [DIGIT_W-1:0] digit,
    input  logic               blank,
    output logic [SEG_W-1:0]   seg_c
);

    // Blank wins over the digit pattern.
    always_comb begin
        seg_c = SEG_TABLE[digit];
        if (blank) begin
            seg_c = SEG_BLANK;
        end
    end

endmodule

// File: rtl/alu_result_display.sv
// Captures an ALU result, converts it to three BCD digits (shift-add-3, or
// direct unpack when s==2'b10) and scans them onto a 3-digit 7-segment display.
// Build option: define ALU_DISP_BLANK_EN to blank leading zeros.
module alu_result_display
    import alu_disp_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 50000
)
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic [Y_W-1:0]   y,
    input  logic [1:0]       s,
    input  logic             load,
    output logic             busy,
    output logic             done,
    output logic [2:0]       an,
    output logic [SEG_W-1:0] seg
);

    localparam int unsigned DIV_W  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned DISP_W = NUM_DIGITS * DIGIT_W;
    localparam int unsigned SR_W   = DISP_W + Y_W;

    state_t             state_q, state_d;
    logic [SR_W-1:0]    sr_q, sr_d, sr_adj, sr_shift;
    logic [2:0]         cnt_q, cnt_d;
    logic               bcd_q, bcd_d;
    logic [DISP_W-1:0]  disp_q, disp_d;
    logic               busy_d, done_d;

    logic [DIV_W-1:0]   div_q, div_d;
    logic [1:0]         idx_q, idx_d;
    logic [2:0]         an_d;
    logic [DIGIT_W-1:0] scan_digit;
    logic               scan_blank;
    logic [SEG_W-1:0]   scan_seg;

    // Conversion state and display register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sr_q    <= '0;
            cnt_q   <= '0;
            bcd_q   <= 1'b0;
            disp_q  <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            sr_q    <= sr_d;
            cnt_q   <= cnt_d;
            bcd_q   <= bcd_d;
            disp_q  <= disp_d;
            busy    <= busy_d;
            done    <= done_d;
        end
    end

    // Next-state, shift-add-3 step and commit of the finished digits.
    always_comb begin
        state_d = state_q;
        sr_d    = sr_q;
        cnt_d   = cnt_q;
        bcd_d   = bcd_q;
        disp_d  = disp_q;
        done_d  = 1'b0;

        sr_adj = sr_q;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (sr_q[Y_W + DIGIT_W*i +: DIGIT_W] >= 4'd5) begin
                sr_adj[Y_W + DIGIT_W*i +: DIGIT_W] = sr_q[Y_W + DIGIT_W*i +: DIGIT_W] + 4'd3;
            end
        end
        // MSB after adjustment is always zero for an 8-bit operand.
        sr_shift = SR_W'({sr_adj, 1'b0});

        unique case (state_q)
            IDLE: begin
                if (load) begin
                    sr_d    = SR_W'(y);
                    bcd_d   = (s == 2'b10);
                    cnt_d   = '0;
                    state_d = CONV;
                end
            end
            CONV: begin
                if (bcd_q) begin
                    disp_d  = DISP_W'(sr_q[Y_W-1:0]);
                    state_d = COMMIT;
                    done_d  = 1'b1;
                end else begin
                    sr_d  = sr_shift;
                    cnt_d = cnt_q + 3'd1;
                    if (cnt_q == 3'd7) begin
                        disp_d  = sr_shift[SR_W-1:Y_W];
                        state_d = COMMIT;
                        done_d  = 1'b1;
                    end
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // Free-running scan divider, digit index and registered an/seg.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q <= '0;
            idx_q <= '0;
            an    <= 3'b110;
            seg   <= SEG_TABLE[0];
        end else begin
            div_q <= div_d;
            idx_q <= idx_d;
            an    <= an_d;
            seg   <= scan_seg;
        end
    end

    // Divider wrap advances the digit; select the digit and its blank flag.
    always_comb begin
        div_d = div_q + DIV_W'(1);
        idx_d = idx_q;
        if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            idx_d = (idx_q == 2'd2) ? 2'd0 : idx_q + 2'd1;
        end

        unique case (idx_d)
            2'd0: begin
                an_d       = 3'b110;
                scan_digit = disp_q[3:0];
            end
            2'd1: begin
                an_d       = 3'b101;
                scan_digit = disp_q[7:4];
            end
            default: begin
                an_d       = 3'b011;
                scan_digit = disp_q[11:8];
            end
        endcase

`ifdef ALU_DISP_BLANK_EN
        scan_blank = ((idx_d == 2'd2) && (disp_q[11:8] == 4'd0)) ||
                     ((idx_d == 2'd1) && (disp_q[11:4] == 8'd0));
`else
        scan_blank = 1'b0;
`endif
    end

    seg7_decode u_seg7_decode (
        .digit (scan_digit),
        .blank (scan_blank),
        .seg_c (scan_seg)
    );

endmodule

// File: tb/tb_alu_result_display.sv
// Scoreboard bench for alu_result_display: stimulus pushes expected latency and
// per-digit segment patterns; a monitor pops on each done pulse and checks them.
module tb_alu_result_display;

    localparam int unsigned SCAN_DIV = 4;

    localparam logic [6:0] S0 = 7'b1000000;
    localparam logic [6:0] S1 = 7'b1111001;
    localparam logic [6:0] S2 = 7'b0100100;
    localparam logic [6:0] S3 = 7'b0110000;
    localparam logic [6:0] S4 = 7'b0011001;
    localparam logic [6:0] S5 = 7'b0010010;
    localparam logic [6:0] S9 = 7'b0010000;
    localparam logic [6:0] SE = 7'b0000110;
    localparam logic [6:0] SB = 7'b1111111;
`ifdef ALU_DISP_BLANK_EN
    localparam logic [6:0] LZ = SB;
`else
    localparam logic [6:0] LZ = S0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] y = 8'd0;
    logic [1:0] s = 2'd0;
    logic       load = 1'b0;
    logic       busy, done;
    logic [2:0] an;
    logic [6:0] seg;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;

    typedef struct {
        int         load_cyc;
        int         lat;
        logic [6:0] sh;
        logic [6:0] st;
        logic [6:0] su;
    } exp_t;

    exp_t q[$];

    alu_result_display #(.SCAN_DIV(SCAN_DIV)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .y     (y),
        .s     (s),
        .load  (load),
        .busy  (busy),
        .done  (done),
        .an    (an),
        .seg   (seg)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Scoreboard monitor: latency, pulse width and the scanned digits after commit.
    initial begin : monitor
        exp_t       e;
        logic [6:0] want;
        logic       legal;
        forever begin
            @(negedge clk);
            if (done === 1'b1) begin
                if (q.size() == 0) begin
                    check("unexpected_done", 32'(done), 32'd0);
                end else begin
                    e = q.pop_front();
                    check("done_latency", 32'(cyc - e.load_cyc), 32'(e.lat));
                    @(negedge clk);
                    check("done_width", 32'(done), 32'd0);
                    for (int j = 0; j < 12; j++) begin
                        @(negedge clk);
                        legal = 1'b1;
                        want  = e.su;
                        case (an)
                            3'b110:  want = e.su;
                            3'b101:  want = e.st;
                            3'b011:  want = e.sh;
                            default: legal = 1'b0;
                        endcase
                        if (legal) begin
                            check("scan_seg", 32'(seg), 32'(want));
                        end else begin
                            check("an_onehot", 32'(an), 32'(3'b110));
                        end
                    end
                end
            end
        end
    end

    // Called on the negedge reset is released: checks scan order and digits.
    task automatic scan_check(input logic [6:0] sh, input logic [6:0] st, input logic [6:0] su);
        logic [2:0] exp_an;
        logic [6:0] exp_seg;
        for (int j = 0; j < 12; j++) begin
            case ((j / 4) % 3)
                0:       begin exp_an = 3'b110; exp_seg = su; end
                1:       begin exp_an = 3'b101; exp_seg = st; end
                default: begin exp_an = 3'b011; exp_seg = sh; end
            endcase
            check("scan_an", 32'(an), 32'(exp_an));
            check("scan_seg_reset", 32'(seg), 32'(exp_seg));
            @(negedge clk);
        end
    endtask

    // One conversion; extra_at>0 pulses a second load (y=7) that must be ignored.
    task automatic run_op(input logic [7:0] yv, input logic [1:0] sv, input int lat,
                          input logic [6:0] sh, input logic [6:0] st, input logic [6:0] su,
                          input int extra_at);
        exp_t e;
        e.load_cyc = cyc;
        e.lat      = lat;
        e.sh       = sh;
        e.st       = st;
        e.su       = su;
        q.push_back(e);
        y    = yv;
        s    = sv;
        load = 1'b1;
        for (int i = 1; i <= lat; i++) begin
            @(negedge clk);
            load = (i == extra_at);
            if (i == extra_at) begin
                y = 8'd7;
                s = 2'b00;
            end
            check("busy_during", 32'(busy), 32'd1);
        end
        @(negedge clk);
        load = 1'b0;
        check("busy_after", 32'(busy), 32'd0);
        repeat (16) @(negedge clk);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        check("reset_busy", 32'(busy), 32'd0);
        check("reset_done", 32'(done), 32'd0);
        scan_check(LZ, LZ, S0);

        run_op(8'hFF, 2'b01, 9, S2, S5, S5, 0);
        run_op(8'h13, 2'b10, 2, LZ, S1, S3, 0);
        run_op(8'h1C, 2'b10, 2, LZ, S1, SE, 0);
        run_op(8'd100, 2'b11, 9, S1, S0, S0, 0);
        run_op(8'd42, 2'b00, 9, LZ, S4, S2, 0);
        run_op(8'h99, 2'b10, 2, LZ, S9, S9, 0);
        run_op(8'hFF, 2'b00, 9, S2, S5, S5, 3);
        run_op(8'd5, 2'b00, 9, LZ, LZ, S5, 0);
        run_op(8'd0, 2'b01, 9, LZ, LZ, S0, 0);

        // Abort a conversion of 200 with reset four cycles after load.
        y    = 8'd200;
        s    = 2'b00;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
        repeat (3) @(negedge clk);
        check("pre_abort_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        scan_check(LZ, LZ, S0);

        check("pending_results", 32'(q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/alu_result_display.md
ALU_RESULT_DISPLAY -- requirements
Module: alu_result_display

Interface
REQ-001 SHALL have parameter SCAN_DIV, default 50000, meaning clk cycles per digit-scan slot (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1, reset that is asynchronous and active-low.
REQ-004 SHALL have port y, input, 8, the ALU result word.
REQ-005 SHALL have port s, input, 2, the ALU op select; 2'b10 marks y as packed BCD ({tens, units}).
REQ-006 SHALL have port load, input, 1, a one-cycle strobe that requests capture of y and s.
REQ-007 SHALL have port busy, output, 1, high while a conversion is in progress.
REQ-008 SHALL have port done, output, 1, a one-cycle pulse when the display register updates.
REQ-009 SHALL have port an, output, 3, active-low one-hot digit enable (bit0 units, bit1 tens, bit2 hundreds).
REQ-010 SHALL have port seg, output, 7, active-low segments ordered gfedcba.

Function
REQ-011 SHALL implement FSM states IDLE, CONV, COMMIT: IDLE->CONV on load; CONV->COMMIT after the last shift; COMMIT->IDLE unconditionally.
REQ-012 SHALL sample y and s only when load=1 in IDLE; load in CONV or COMMIT SHALL be ignored (no queuing).
REQ-013 SHALL, for s!=2'b10, convert y to 3 BCD digits by shift-add-3 with one shift per cycle, 8 cycles in CONV.
REQ-014 SHALL, for s==2'b10, spend 1 cycle in CONV, loading digits {0, y[7:4], y[3:0]} without arithmetic.
REQ-015 SHALL assert done for exactly the COMMIT cycle: 9 cycles after the load edge in binary mode, 2 cycles after in BCD mode.
REQ-016 SHALL assert busy in CONV and COMMIT and deassert it in IDLE.
REQ-017 SHALL hold the previous display value until COMMIT, so the display never shows partial conversion results.
REQ-018 SHALL show any digit nibble >9 as "E" (seg=7'b0000110); this case is reachable only in BCD mode.
REQ-019 SHALL count a scan divider 0..SCAN_DIV-1 continuously, independent of the FSM; on wrap it SHALL advance the digit index 0->1->2->0.
REQ-020 SHALL register an and seg so they change on the same edge, with no cycle where two digits are enabled.
REQ-021 SHALL decode digits 0-9 to the standard active-low gfedcba patterns (0=7'b1000000, 1=7'b1111001, ... 9=7'b0010000).

Reset
REQ-022 SHALL on rst_n=0 set FSM=IDLE, busy=0, done=0, display digits=0, divider=0, digit index=0, an=3'b110, seg=7'b1000000.
REQ-023 SHALL abort a conversion if reset is asserted mid-operation, with no done pulse and the display cleared to 0.

Configuration
REQ-024 SHALL, when ALU_DISP_BLANK_EN is defined, blank leading zeros (seg=7'b1111111): hundreds if 0; tens if hundreds and tens are both 0; units never.
REQ-025 SHALL, when ALU_DISP_BLANK_EN is undefined, show all three digits including leading zeros; an scanning is identical in both builds.

Structure
REQ-026 SHALL place the FSM state enum, the NUM_DIGITS=3 constant, and segment constants (blank, E, 0-9 table) in a shared package alu_disp_pkg.
REQ-027 SHALL use one sub-module seg7_decode (4-bit nibble plus blank flag in, 7-bit active-low segments out, combinational), instantiated once on the scanned digit.

Verification
REQ-028 SHALL cover: reset, then SCAN_DIV=4 -> an cycles 110,101,011 every 4 clocks, seg=7'b1000000 throughout.
REQ-029 SHALL cover: y=8'hFF, s=2'b01, load pulse -> busy for 9 cycles, done on cycle 9, digits 2,5,5.
REQ-030 SHALL cover: y=8'h13, s=2'b10 -> done on cycle 2, digits 0,1,3; y=8'h1C, s=2'b10 -> units digit shows 7'b0000110.
REQ-031 SHALL cover: a second load 3 cycles into a conversion (y=8'd7) -> ignored, result stays 255 from the first load.
REQ-032 SHALL cover: rst_n low 4 cycles after load of y=8'd200 -> no done, display 000, busy=0 immediately.
REQ-033 SHALL cover: y=8'd5 with ALU_DISP_BLANK_EN -> hundreds and tens seg=7'b1111111, units=7'b0010010; without the macro -> 0,0,5.
